ltc2624_tx: RTL
===============

# ltc2624_tx

Frame-level SPI transmitter for the LTC2624 quad 12-bit DAC on the SPI bus. It accepts one DAC command per handshake and serialises it as a 32-bit SPI mode-0 frame, driving `cs`, `sck` and `mosi` directly. It also captures the 32-bit word echoed on `miso`. It sits directly below the DAC control logic (`spidac`), which decides what to write, and above the board pins `DAC_CS`, `DAC_CLR`, `SPI_SCK`, `SPI_MOSI` and `SPI_MISO`.

## Interface
- `CDIV`, default 50: length of each SCK phase in `clk` cycles. SCK period is 2·CDIV. Legal values are CDIV ≥ 2; elaboration fails below that.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd` in 4: LTC2624 command nibble.
- `addr` in 4: DAC address nibble (4'hF selects all channels).
- `data` in 12: DAC code.
- `busy` out 1: high from accept until the return to IDLE.
- `rsp_valid` out 1: one-cycle pulse when a frame completes.
- `rsp` out 32: word captured from `miso`; stable until the next `rsp_valid`.
- `cs` out 1: DAC chip select, active low.
- `clr` out 1: DAC asynchronous clear, active low.
- `sck` out 1: SPI clock, idles low.
- `mosi` out 1: SPI data out.
- `miso` in 1: SPI data in from the DAC.

## Operation
- **Frame contents.** Frame = {8'h00, cmd, addr, data, 4'h0}, sent MSB first. The frame is latched into a 32-bit shift register on the accept cycle (`cmd_valid && cmd_ready`).
- **States:**
  - IDLE → SETUP on accept.
  - SETUP (CDIV cycles): `cs`=0, `sck`=0, `mosi`=bit31.
  - SHIFT: 32 bits, each a high phase of CDIV cycles followed by a low phase of CDIV cycles.
  - GAP (CDIV cycles): `cs`=1.
  - GAP → IDLE.
- **Shifting rules:**
  - `miso` is sampled into `rsp_shift` on the clk edge where `sck` rises.
  - `mosi` advances to the next bit on the edge where `sck` falls.
  - After bit0's falling edge, `mosi` is held at bit0 through the end of that low phase (hold time). It goes to 0 when `cs` rises.
- **Frame end.** At the end of the 32nd low phase:
  - `cs` rises;
  - `rsp` is loaded;
  - `rsp_valid` pulses for that same cycle.
- **Commands while busy.** A `cmd_valid` asserted outside IDLE is not accepted. The upstream block must hold it; it is taken on the first IDLE cycle.
- **`clr`.** Driven 0 while `rst`=1, then 1 from the cycle after `rst` deasserts. `clr` is not affected by frames.
- **Counters:**
  - Phase counter of width $clog2(CDIV), wrapping at CDIV−1.
  - Bit counter of 6 bits, terminal value 32 half-period pairs.

## Timing
- Accept occurs at cycle 0.
- `cs` falls at cycle 1 and stays low for exactly 65·CDIV cycles.
- First `sck` rise is at cycle 1+CDIV.
- 32 `sck` rising edges per frame, no more and no fewer.
- `cs` rises at cycle 1+65·CDIV; `rsp_valid` is high in that same cycle.
- `cmd_ready` returns high at cycle 1+66·CDIV, so `cs` is high for at least CDIV+1 cycles between frames.
- Back-to-back frames (`cmd_valid` held): the next `cs` fall comes 1 cycle after `cmd_ready` rises.
- Outputs while `rst` is high and in the cycle after:

| Output | Value during `rst` | Value in first cycle after `rst` deasserts |
|---|---|---|
| `cs` | 1 | 1 |
| `sck` | 0 | 0 |
| `mosi` | 0 | 0 |
| `clr` | 0 | 1 |
| `cmd_ready` | 0 | 1 |
| `busy` | 0 | 0 |
| `rsp_valid` | 0 | 0 |
| `rsp` | 32'h0 | 32'h0 |

- Reset mid-frame: all outputs take their reset values on the next edge. There is no `rsp_valid` and no partial `sck` pulse after that edge. The next accepted frame is complete and correct.

## Configuration
- Macro: `LTC2624_READBACK_EN`.
- **Defined:** `miso` capture, `rsp` and `rsp_valid` operate as specified above.
- **Undefined:**
  - The `rsp` and `rsp_valid` ports remain but are tied to 0.
  - `miso` is ignored and the capture shift register is removed.
  - The `mosi`, `cs` and `sck` behaviour and all timing are identical to the defined case.

## Test plan
- **Reset values:** hold `rst` for 5 cycles → `cs`=1, `sck`=0, `mosi`=0, `clr`=0, `cmd_ready`=0 during reset. One cycle after release: `clr`=1, `cmd_ready`=1.
- **Single frame:** CDIV=2; `cmd`=4'h3, `addr`=4'hF, `data`=12'hABC → slave model captures 32'h003FABC0 on rising edges. Check 32 `sck` rises, `cs` low 130 cycles, `cmd_ready` high again at cycle 133.
- **Readback** (`LTC2624_READBACK_EN` defined): the `miso` model echoes the previous frame. Send the frame above and then `cmd`=4'h0, `data`=12'h123 → second `rsp_valid` carries `rsp`=32'h003FABC0.
- **Back-to-back:** hold `cmd_valid` for 3 frames → exactly 3 `cs` low windows. Between frames, `cs` is high ≥ CDIV+1 cycles, and each `rsp_valid` is a single-cycle pulse coincident with the `cs` rise.
- **Reset mid-frame:** assert `rst` for 1 cycle after the 10th `sck` rise → `cs`=1 and `sck`=0 on the next edge; no `rsp_valid`. A following frame with `data`=12'h555 captures 32'h003F5550.
- **Readback disabled:** build without `LTC2624_READBACK_EN` and toggle `miso` randomly over 2 frames → `rsp_valid` stays 0, `rsp`=0, and `mosi` frames are unchanged.

Source files
------------

// File: rtl/ltc2624_tx.sv
// ltc2624_tx -- frame-level SPI (mode 0) transmitter for the LTC2624 quad 12-bit DAC.
//
// Takes one command per cmd_valid/cmd_ready handshake. Each command is sent
// MSB first as the 32-bit frame {8'h00, cmd, addr, data, 4'h0}. The word that
// comes back on miso is captured at the same time.
//
// Frame timing, with the accept at cycle 0:
//   SETUP : cs low, sck low, mosi = bit31. Lasts CDIV cycles.
//   SHIFT : 32 bits. Each bit is a high phase of CDIV cycles, then a low phase
//           of CDIV cycles.
//   GAP   : cs high for CDIV cycles, then the FSM returns to IDLE.
//
// Parameters:
//   CDIV       length of one sck phase, in clk cycles (must be >= 2)
//
// Ports:
//   clk, rst   system clock; synchronous active-high reset
//   cmd_valid  command request. It is held by the source until cmd_ready.
//   cmd_ready  high only in IDLE
//   cmd/addr   LTC2624 command and address nibbles
//   data       12-bit DAC code
//   busy       high from the accept until the return to IDLE
//   rsp_valid  one-cycle pulse at frame end (same cycle as the cs rise)
//   rsp        word captured from miso. It holds until the next rsp_valid.
//   cs, sck, mosi, miso   SPI pins (cs active low, sck idles low)
//   clr        DAC clear, active low. It is 0 during reset and 1 afterwards.
//
// Configuration:
//   LTC2624_READBACK_EN  when defined, miso is captured and rsp/rsp_valid are
//                        driven. When undefined, miso is ignored and
//                        rsp/rsp_valid are tied to 0. Pin timing is the same
//                        in both builds.
module ltc2624_tx #(
  parameter int CDIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd,
  input  logic [3:0]  addr,
  input  logic [11:0] data,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp,
  output logic        cs,
  output logic        clr,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  generate
    if (CDIV < 2) begin : g_bad_cdiv
      $error("ltc2624_tx: CDIV must be >= 2");
    end
  endgenerate

  localparam int               CNT_W    = $clog2(CDIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CDIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [5:0]       bit_cnt;
  // Holds the 31 bits that have not yet been presented on mosi.
  // Bit 31 goes straight to mosi on the accept.
  logic [30:0]      tx_shift;
  logic [31:0]      frame_in;

  logic accept;
  logic phase_end;
  logic rise_evt;
  logic fall_evt;
  logic done_evt;

  assign frame_in  = {8'h00, cmd, addr, data, 4'h0};
  assign accept    = cmd_valid && cmd_ready;
  assign phase_end = (phase_cnt == CNT_LAST);
  // sck rises at the end of SETUP. It also rises at the end of every low
  // phase except the one after the 32nd bit.
  assign rise_evt  = phase_end &&
                     ((state == SETUP) ||
                      (state == SHIFT && !sck && bit_cnt != 6'd32));
  assign fall_evt  = phase_end && (state == SHIFT) && sck;
  assign done_evt  = phase_end && (state == SHIFT) && !sck && (bit_cnt == 6'd32);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      cs        <= 1'b1;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      clr       <= 1'b0;
    end else begin
      clr <= 1'b1;
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          cmd_ready <= 1'b1;
          if (accept) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cs        <= 1'b0;
            mosi      <= frame_in[31];
            bit_cnt   <= '0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            phase_cnt <= '0;
            state     <= SHIFT;
            sck       <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (sck) begin
              sck     <= 1'b0;
              bit_cnt <= bit_cnt + 6'd1;
              // After bit0's falling edge, mosi keeps bit0 for the hold time.
              if (bit_cnt != 6'd31) begin
                mosi <= tx_shift[30];
              end
            end else if (bit_cnt == 6'd32) begin
              state <= GAP;
              cs    <= 1'b1;
              mosi  <= 1'b0;
            end else begin
              sck <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (phase_end) begin
            phase_cnt <= '0;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tx_shift <= frame_in[30:0];
    end else if (fall_evt) begin
      tx_shift <= {tx_shift[29:0], 1'b0};
    end
  end

`ifdef LTC2624_READBACK_EN
  logic [31:0] rsp_shift;

  always_ff @(posedge clk) begin
    if (rise_evt) begin
      rsp_shift <= {rsp_shift[30:0], miso};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp       <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= done_evt;
      if (done_evt) begin
        rsp <= rsp_shift;
      end
    end
  end
`else
  logic unused_readback;

  assign rsp             = '0;
  assign rsp_valid       = 1'b0;
  assign unused_readback = miso ^ rise_evt ^ done_evt;
`endif

endmodule
